cache_ctrl_wb: RTL and testbench
================================

// Module: cache_ctrl_wb
// PURPOSE
//  Sequencing controller for a write-back, write-allocate, direct-mapped cache between a CPU port and a
//  multi-cycle main memory. Owns tag/valid/dirty/data storage, the hit/miss FSM, dirty-block eviction
//  and block refill via a req/ready handshake. Sits between the processor model and the main-memory model.
// PARAMETERS
//  ADDR_W      10  byte address width (CPU and memory)
//  DATA_W      32  word width
//  INDEX_W      2  index bits -> 2**INDEX_W lines
//  WOFF_W       2  word-in-block bits -> 2**WOFF_W words per block; byte offset fixed at 2 bits
// PORTS
//  clk           in   1                  clock, all state on rising edge
//  reset         in   1                  synchronous, active-high
//  cpuReq        in   1                  CPU request; held with isRead/address/writeData until ready
//  isRead        in   1                  1 = load, 0 = store
//  address       in   ADDR_W             byte address {tag, index, woff, 2'b00}
//  writeData     in   DATA_W             store data
//  readData      out  DATA_W             load result, valid while ready=1
//  isHit         out  1                  1 = request hit on first compare, valid while ready=1
//  ready         out  1                  one-cycle completion pulse
//  memReq        out  1                  memory request, held until memReady
//  memWrite      out  1                  1 = block write (eviction), 0 = block read (refill)
//  memAddr       out  ADDR_W             block-aligned byte address (woff and byte bits = 0)
//  memWriteData  out  DATA_W<<WOFF_W     evicted block, word 0 in LSBs
//  memReadData   in   DATA_W<<WOFF_W     refill block, sampled when memReady=1
//  memReady      in   1                  one-cycle completion from memory
// BEHAVIOUR
//  Reset: state=IDLE; all valid/dirty=0; ready=0, isHit=0, readData=0, memReq=0, memWrite=0, memAddr=0,
//   memWriteData=0. Reset mid-transaction aborts it: memReq drops next edge, no cache update, no ready.
//  Tag = address[ADDR_W-1 : 2+WOFF_W+INDEX_W]; index = next INDEX_W bits; woff = address[2+WOFF_W-1:2].
//  FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE (registered outputs throughout).
//   IDLE: cpuReq=1 -> latch isRead/address/writeData, go COMPARE; else stay. Requests while busy ignored.
//   COMPARE: hit = valid[idx] && tag[idx]==reqTag.
//    hit: load -> readData<=word; store -> write word, dirty[idx]<=1; ready<=1 next cycle;
//     isHit<=firstTry; -> IDLE.
//    miss, line clean/invalid: firstTry<=0; memReq<=1, memWrite<=0, memAddr<=req block -> ALLOCATE.
//    miss, line valid+dirty: firstTry<=0; memReq<=1, memWrite<=1, memAddr<={tag[idx],idx,0},
//     memWriteData<=block[idx] -> WRITEBACK.
//   WRITEBACK: hold outputs until memReady=1; then dirty[idx]<=0, issue refill read -> ALLOCATE.
//   ALLOCATE: hold until memReady=1; then block[idx]<=memReadData, tag<=reqTag, valid<=1, dirty<=0,
//    memReq<=0 -> COMPARE (second compare always hits; store then merges and sets dirty).
//  Latency (cpuReq sampled in cycle 0): hit -> ready in cycle 2; clean miss -> 3 + mem latency;
//   dirty miss -> 4 + 2*mem latency (each mem op counted from memReq rise to memReady).
//  ready, isHit, readData update only on completion; ready is exactly one cycle. A cpuReq still high
//   in the cycle after ready is a new request.
//  memReq never drops before memReady; memReady with memReq=0 is ignored. Memory must not
//   return memReady in the same cycle memReq rises.
//  Store readData: unchanged (holds last load value). isHit=0 for any request that visited memory.
// STRUCTURE
//  Shared include cache_defs.vh: state encodings, field-width/offset constants, tag/index/woff slice macros.
//  Sub-module cache_line_array: valid/dirty/tag/data regs, 1 read port (comb), 1 word-write port,
//   1 block-fill port, dirty clear; reset clears valid/dirty only. FSM + handshake remain in cache_ctrl_wb.
// TESTING (memory model 3-cycle latency; mem[0x000]=0x00003cc3, mem[0x200]=0x00000ccc, mem[0x300]=0x000000c3)
//  1 load 0x000 after reset -> miss, memReq read memAddr=0x000, ready w/ isHit=0 readData=0x00003cc3.
//  2 store 0x000 data 0x000000ff, then load 0x000 -> both isHit=1, ready at cycle 2; load 0x000000ff;
//   memory word 0x000 still 0x00003cc3, no memReq issued (write-back).
//  3 load 0x200 -> isHit=0; WRITEBACK memAddr=0x000 with word0=0x000000ff, then read 0x200;
//   readData=0x00000ccc; memory word 0x000 now 0x000000ff.
//  4 load 0x000 then 0x300 (both clean evictions) -> no WRITEBACK; readData 0x000000ff then 0x000000c3.
//  5 reset asserted during ALLOCATE -> memReq=0 next cycle, no ready; load 0x000 after -> miss (valid cleared).
//  6 cpuReq held high through a hit plus one cycle past ready -> second request starts; ready exactly 1 cycle each.

Source files
------------

// File: rtl/cache_ctrl_wb_pkg.sv
// Shared types and default geometry for the write-back, write-allocate cache controller.
package cache_ctrl_wb_pkg;

  localparam int unsigned DEF_ADDR_W  = 10;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_INDEX_W = 2;
  localparam int unsigned DEF_WOFF_W  = 2;
  localparam int unsigned BYTE_OFF_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARE   = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_ALLOCATE  = 2'd3
  } state_t;

endpackage

// File: rtl/cache_ctrl_wb_line_array.sv
// Direct-mapped line storage: valid/dirty/tag/data per line, combinational read,
// word write (marks dirty), block fill (valid, clean) and dirty clear. Reset clears valid/dirty only.
module cache_ctrl_wb_line_array #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INDEX_W = 2,
  parameter int unsigned WOFF_W  = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [INDEX_W-1:0]         rd_idx_i,
  output logic                       rd_valid_o,
  output logic                       rd_dirty_o,
  output logic [TAG_W-1:0]           rd_tag_o,
  output logic [(DATA_W<<WOFF_W)-1:0] rd_block_o,
  input  logic                       wr_en_i,
  input  logic [INDEX_W-1:0]         wr_idx_i,
  input  logic [WOFF_W-1:0]          wr_woff_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       fill_en_i,
  input  logic [INDEX_W-1:0]         fill_idx_i,
  input  logic [TAG_W-1:0]           fill_tag_i,
  input  logic [(DATA_W<<WOFF_W)-1:0] fill_block_i,
  input  logic                       clr_dirty_i,
  input  logic [INDEX_W-1:0]         clr_idx_i
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned BLK_W = DATA_W << WOFF_W;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [BLK_W-1:0] data_q [LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_block_o = data_q[rd_idx_i];

  // Fill wins over a same-cycle word write on dirty; the controller never issues both.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (clr_dirty_i) dirty_q[clr_idx_i] <= 1'b0;
      if (wr_en_i)     dirty_q[wr_idx_i]  <= 1'b1;
      if (fill_en_i) begin
        valid_q[fill_idx_i] <= 1'b1;
        dirty_q[fill_idx_i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_idx_i]  <= fill_tag_i;
      data_q[fill_idx_i] <= fill_block_i;
    end
    if (wr_en_i) begin
      data_q[wr_idx_i][int'(wr_woff_i)*DATA_W +: DATA_W] <= wr_data_i;
    end
  end

endmodule

// File: rtl/cache_ctrl_wb.sv
// Write-back, write-allocate, direct-mapped cache controller: hit/miss FSM, dirty eviction,
// block refill over a req/ready memory handshake. All outputs are registered.
module cache_ctrl_wb
  import cache_ctrl_wb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned INDEX_W = DEF_INDEX_W,
  parameter int unsigned WOFF_W  = DEF_WOFF_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cpuReq,
  input  logic                        isRead,
  input  logic [ADDR_W-1:0]           address,
  input  logic [DATA_W-1:0]           writeData,
  output logic [DATA_W-1:0]           readData,
  output logic                        isHit,
  output logic                        ready,
  output logic                        memReq,
  output logic                        memWrite,
  output logic [ADDR_W-1:0]           memAddr,
  output logic [(DATA_W<<WOFF_W)-1:0] memWriteData,
  input  logic [(DATA_W<<WOFF_W)-1:0] memReadData,
  input  logic                        memReady,
  output state_t                      dbgState
);

  localparam int unsigned IDX_LSB = BYTE_OFF_W + WOFF_W;
  localparam int unsigned TAG_LSB = IDX_LSB + INDEX_W;
  localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;
  localparam int unsigned BLK_W   = DATA_W << WOFF_W;

  state_t              state_q, state_d;
  logic                req_read_q, req_read_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_data_q, req_data_d;
  logic                first_try_q, first_try_d;
  logic [DATA_W-1:0]   read_data_q, read_data_d;
  logic                is_hit_q, is_hit_d;
  logic                ready_q, ready_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BLK_W-1:0]    mem_wdata_q, mem_wdata_d;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [WOFF_W-1:0]   req_woff;
  logic [1:0]          unused_byte_off;
  logic [ADDR_W-1:0]   req_blk_addr;

  logic                line_valid, line_dirty, line_hit;
  logic [TAG_W-1:0]    line_tag;
  logic [BLK_W-1:0]    line_block;
  logic [DATA_W-1:0]   hit_word;
  logic                wr_en, fill_en, clr_dirty;

  assign req_tag         = req_addr_q[ADDR_W-1:TAG_LSB];
  assign req_idx         = req_addr_q[TAG_LSB-1:IDX_LSB];
  assign req_woff        = req_addr_q[IDX_LSB-1:BYTE_OFF_W];
  assign unused_byte_off = req_addr_q[1:0];
  assign req_blk_addr    = {req_tag, req_idx, {IDX_LSB{1'b0}}};

  assign line_hit = line_valid && (line_tag == req_tag);
  assign hit_word = line_block[int'(req_woff)*DATA_W +: DATA_W];

  cache_ctrl_wb_line_array #(
    .DATA_W  (DATA_W),
    .INDEX_W (INDEX_W),
    .WOFF_W  (WOFF_W),
    .TAG_W   (TAG_W)
  ) u_lines (
    .clk          (clk),
    .reset        (reset),
    .rd_idx_i     (req_idx),
    .rd_valid_o   (line_valid),
    .rd_dirty_o   (line_dirty),
    .rd_tag_o     (line_tag),
    .rd_block_o   (line_block),
    .wr_en_i      (wr_en && !reset),
    .wr_idx_i     (req_idx),
    .wr_woff_i    (req_woff),
    .wr_data_i    (req_data_q),
    .fill_en_i    (fill_en && !reset),
    .fill_idx_i   (req_idx),
    .fill_tag_i   (req_tag),
    .fill_block_i (memReadData),
    .clr_dirty_i  (clr_dirty && !reset),
    .clr_idx_i    (req_idx)
  );

  // Memory handshake: memReq rises with memWrite/memAddr/memWriteData stable and holds them
  // until a cycle with memReady=1; that cycle completes the transfer and memReq drops on the
  // next edge. memReady seen while memReq=0 is ignored. Each block transfer is a fresh memReq
  // rise, so an eviction is followed by one idle cycle before the refill request.
  always_comb begin
    state_d     = state_q;
    req_read_d  = req_read_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    first_try_d = first_try_q;
    read_data_d = read_data_q;
    is_hit_d    = is_hit_q;
    ready_d     = 1'b0;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_en       = 1'b0;
    fill_en     = 1'b0;
    clr_dirty   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cpuReq) begin
          req_read_d  = isRead;
          req_addr_d  = address;
          req_data_d  = writeData;
          first_try_d = 1'b1;
          state_d     = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (line_hit) begin
          if (req_read_q) read_data_d = hit_word;
          else            wr_en       = 1'b1;
          ready_d  = 1'b1;
          is_hit_d = first_try_q;
          state_d  = ST_IDLE;
        end else if (line_valid && line_dirty) begin
          first_try_d = 1'b0;
          mem_req_d   = 1'b1;
          mem_write_d = 1'b1;
          mem_addr_d  = {line_tag, req_idx, {IDX_LSB{1'b0}}};
          mem_wdata_d = line_block;
          state_d     = ST_WRITEBACK;
        end else begin
          first_try_d = 1'b0;
          mem_req_d   = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = req_blk_addr;
          state_d     = ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        if (mem_req_q && memReady) begin
          clr_dirty   = 1'b1;
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
          mem_addr_d  = req_blk_addr;
          state_d     = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (memReady) begin
          fill_en   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_COMPARE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_read_q  <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      first_try_q <= 1'b0;
      read_data_q <= '0;
      is_hit_q    <= 1'b0;
      ready_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_read_q  <= req_read_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      first_try_q <= first_try_d;
      read_data_q <= read_data_d;
      is_hit_q    <= is_hit_d;
      ready_q     <= ready_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign readData     = read_data_q;
  assign isHit        = is_hit_q;
  assign ready        = ready_q;
  assign memReq       = mem_req_q;
  assign memWrite     = mem_write_q;
  assign memAddr      = mem_addr_q;
  assign memWriteData = mem_wdata_q;
  assign dbgState     = state_q;

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Directed bench for cache_ctrl_wb with a 3-cycle block memory model and hand-computed expectations.
module tb_cache_ctrl_wb;
  import cache_ctrl_wb_pkg::*;

  localparam int MEM_LAT = 3;

  logic         clk;
  logic         reset;
  logic         cpuReq;
  logic         isRead;
  logic [9:0]   address;
  logic [31:0]  writeData;
  logic [31:0]  readData;
  logic         isHit;
  logic         ready;
  logic         memReq;
  logic         memWrite;
  logic [9:0]   memAddr;
  logic [127:0] memWriteData;
  logic [127:0] memReadData;
  logic         memReady;
  state_t       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]  mem [256];
  logic [31:0]  exp_q [$];
  logic [9:0]   op_addr_q [$];
  logic         op_wr_q [$];
  logic [127:0] op_wdata_q [$];

  cache_ctrl_wb dut (
    .clk          (clk),
    .reset        (reset),
    .cpuReq       (cpuReq),
    .isRead       (isRead),
    .address      (address),
    .writeData    (writeData),
    .readData     (readData),
    .isHit        (isHit),
    .ready        (ready),
    .memReq       (memReq),
    .memWrite     (memWrite),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .memReadData  (memReadData),
    .memReady     (memReady),
    .dbgState     (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory model: memReady on the MEM_LAT-th cycle of a memReq, once per request
  initial begin
    int cnt;
    bit done;
    int base;
    cnt = 0;
    done = 0;
    memReady = 1'b0;
    memReadData = '0;
    forever begin
      @(posedge clk);
      #1;
      memReady = 1'b0;
      if (!memReq) begin
        cnt = 0;
        done = 0;
      end else if (!done) begin
        cnt++;
        if (cnt == 1) begin
          op_addr_q.push_back(memAddr);
          op_wr_q.push_back(memWrite);
          op_wdata_q.push_back(memWriteData);
        end
        if (cnt == MEM_LAT) begin
          base = int'(memAddr) >> 2;
          for (int w = 0; w < 4; w++) begin
            if (memWrite) mem[base+w] = memWriteData[w*32 +: 32];
            else          memReadData[w*32 +: 32] = mem[base+w];
          end
          memReady = 1'b1;
          done = 1;
        end
      end
    end
  end

  // one CPU access; latency counted in edges after the edge that samples cpuReq
  task automatic cpu_op(input string name, input logic rd, input logic [9:0] addr,
                        input logic [31:0] wd, input logic exp_hit, input logic [31:0] exp_data,
                        input int exp_lat, input int exp_ops);
    int lat;
    logic [31:0] exp_rd;
    op_addr_q.delete();
    op_wr_q.delete();
    op_wdata_q.delete();
    exp_q.push_back(exp_data);
    @(negedge clk);
    cpuReq = 1'b1;
    isRead = rd;
    address = addr;
    writeData = wd;
    @(posedge clk);
    #1;
    cpuReq = 1'b0;
    lat = 999;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = n;
        break;
      end
    end
    exp_rd = exp_q.pop_front();
    check({name, "_latency"}, 128'(lat), 128'(exp_lat));
    check({name, "_isHit"}, 128'(isHit), 128'(exp_hit));
    check({name, "_readData"}, 128'(readData), 128'(exp_rd));
    check({name, "_memops"}, 128'(op_addr_q.size()), 128'(exp_ops));
    @(posedge clk);
    #1;
    check({name, "_ready_pulse"}, 128'(ready), 128'(0));
  endtask

  task automatic check_op(input string name, input int idx, input logic exp_wr,
                          input logic [9:0] exp_addr);
    logic       wr_got;
    logic [9:0] addr_got;
    wr_got = 1'bx;
    addr_got = 'x;
    if (idx < op_addr_q.size()) begin
      wr_got = op_wr_q[idx];
      addr_got = op_addr_q[idx];
    end
    check({name, "_memWrite"}, 128'(wr_got), 128'(exp_wr));
    check({name, "_memAddr"}, 128'(addr_got), 128'(exp_addr));
  endtask

  task automatic check_wdata(input string name, input logic [127:0] exp_blk);
    logic [127:0] got;
    got = 'x;
    if (op_wdata_q.size() > 0) got = op_wdata_q[0];
    check({name, "_memWriteData"}, got, exp_blk);
  endtask

  initial begin
    int ready_seen;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[8'h00] = 32'h0000_3cc3;
    mem[8'h80] = 32'h0000_0ccc;
    mem[8'hc0] = 32'h0000_00c3;
    reset = 1'b1;
    cpuReq = 1'b0;
    isRead = 1'b0;
    address = '0;
    writeData = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 128'(ready), 128'(0));
    check("rst_isHit", 128'(isHit), 128'(0));
    check("rst_readData", 128'(readData), 128'(0));
    check("rst_memReq", 128'(memReq), 128'(0));
    check("rst_memWrite", 128'(memWrite), 128'(0));
    check("rst_memAddr", 128'(memAddr), 128'(0));
    check("rst_memWriteData", memWriteData, 128'(0));
    check("rst_state", 128'(dbg_state), 128'(ST_IDLE));
    reset = 1'b0;

    // cold miss, then write-back hits
    cpu_op("t1_ld000", 1'b1, 10'h000, 32'h0, 1'b0, 32'h0000_3cc3, 5, 1);
    check_op("t1_op0", 0, 1'b0, 10'h000);
    cpu_op("t2_st000", 1'b0, 10'h000, 32'h0000_00ff, 1'b1, 32'h0000_3cc3, 1, 0);
    cpu_op("t2_ld000", 1'b1, 10'h000, 32'h0, 1'b1, 32'h0000_00ff, 1, 0);
    check("t2_mem000", 128'(mem[8'h00]), 128'(32'h0000_3cc3));

    // dirty eviction then refill
    cpu_op("t3_ld200", 1'b1, 10'h200, 32'h0, 1'b0, 32'h0000_0ccc, 9, 2);
    check_op("t3_op0", 0, 1'b1, 10'h000);
    check_wdata("t3_op0", {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'h0000_00ff});
    check_op("t3_op1", 1, 1'b0, 10'h200);
    check("t3_mem000", 128'(mem[8'h00]), 128'(32'h0000_00ff));
    cpu_op("t3_ld204", 1'b1, 10'h204, 32'h0, 1'b1, 32'hA000_0081, 1, 0);

    // clean evictions
    cpu_op("t4_ld000", 1'b1, 10'h000, 32'h0, 1'b0, 32'h0000_00ff, 5, 1);
    check_op("t4a_op0", 0, 1'b0, 10'h000);
    cpu_op("t4_ld300", 1'b1, 10'h300, 32'h0, 1'b0, 32'h0000_00c3, 5, 1);
    check_op("t4b_op0", 0, 1'b0, 10'h300);

    // store miss allocates and merges, then its dirty line is evicted
    cpu_op("s1_st010", 1'b0, 10'h010, 32'h0000_0055, 1'b0, 32'h0000_00c3, 5, 1);
    check_op("s1_op0", 0, 1'b0, 10'h010);
    cpu_op("s2_ld010", 1'b1, 10'h010, 32'h0, 1'b1, 32'h0000_0055, 1, 0);
    cpu_op("s3_ld110", 1'b1, 10'h110, 32'h0, 1'b0, 32'hA000_0044, 9, 2);
    check_op("s3_op0", 0, 1'b1, 10'h010);
    check_wdata("s3_op0", {32'hA000_0007, 32'hA000_0006, 32'hA000_0005, 32'h0000_0055});
    check_op("s3_op1", 1, 1'b0, 10'h110);
    check("s3_mem010", 128'(mem[8'h04]), 128'(32'h0000_0055));

    // cpuReq held one cycle past ready starts a second request
    @(negedge clk);
    cpuReq = 1'b1;
    isRead = 1'b1;
    address = 10'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_ready1", 128'(ready), 128'(1));
    check("t6_isHit1", 128'(isHit), 128'(1));
    check("t6_data1", 128'(readData), 128'(32'h0000_00c3));
    address = 10'h304;
    @(posedge clk); #1;
    check("t6_ready1_low", 128'(ready), 128'(0));
    check("t6_state2", 128'(dbg_state), 128'(ST_COMPARE));
    cpuReq = 1'b0;
    @(posedge clk); #1;
    check("t6_ready2", 128'(ready), 128'(1));
    check("t6_isHit2", 128'(isHit), 128'(1));
    check("t6_data2", 128'(readData), 128'(32'hA000_00C1));
    @(posedge clk); #1;
    check("t6_ready2_low", 128'(ready), 128'(0));
    check("t6_idle", 128'(dbg_state), 128'(ST_IDLE));

    // reset during ALLOCATE aborts the refill and invalidates the cache
    @(negedge clk);
    cpuReq = 1'b1;
    isRead = 1'b1;
    address = 10'h200;
    @(posedge clk); #1;
    cpuReq = 1'b0;
    @(posedge clk); #1;
    check("t5_memReq_up", 128'(memReq), 128'(1));
    check("t5_memAddr", 128'(memAddr), 128'(10'h200));
    check("t5_state_alloc", 128'(dbg_state), 128'(ST_ALLOCATE));
    reset = 1'b1;
    @(posedge clk); #1;
    check("t5_memReq_drop", 128'(memReq), 128'(0));
    check("t5_state_idle", 128'(dbg_state), 128'(ST_IDLE));
    reset = 1'b0;
    ready_seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (ready) ready_seen++;
    end
    check("t5_no_ready", 128'(ready_seen), 128'(0));
    cpu_op("t5_ld000", 1'b1, 10'h000, 32'h0, 1'b0, 32'h0000_00ff, 5, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
